// File: rtl/layer_weight_rx.sv
// Layer weight receiver: streams DEPTH 64-bit words into a local buffer and serves reads once the load completes.
// Optional: define WEIGHT_CHKSUM_EN to add an 8-bit XOR checksum output over all accepted bytes.
module layer_weight_rx #(
    parameter int DEPTH = 144,
    parameter int AW    = 8
) (
    input  logic          sclk,
    input  logic          s_rst,
    input  logic          load_start,
    input  logic [63:0]   weight_data,
    input  logic          weight_valid,
    input  logic          weight_last,
    output logic          ready,
    output logic          load_done,
    output logic          err_short,
    output logic          err_long,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data,
    output logic          rd_valid
`ifdef WEIGHT_CHKSUM_EN
    ,
    output logic [7:0]    chksum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [AW-1:0] END_IDX = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] wr_cnt;
    logic [63:0]   mem [DEPTH];
    logic          beat_acc;
    logic          at_end;
    logic          start;
    logic          addr_ok;

    assign beat_acc = weight_valid & ready;
    assign at_end   = (wr_cnt == END_IDX);
    // load_start while already loading is ignored
    assign start    = (state != LOAD) && (state_nxt == LOAD);
    assign addr_ok  = (32'(rd_addr) < DEPTH);

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (beat_acc && (weight_last || at_end)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            ready     <= 1'b0;
            load_done <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            wr_cnt    <= '0;
        end else begin
            ready     <= (state_nxt == LOAD);
            load_done <= (state_nxt == DONE);
            if (start) begin
                wr_cnt    <= '0;
                err_short <= 1'b0;
                err_long  <= 1'b0;
            end else if (beat_acc) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (weight_last && !at_end) begin
                    err_short <= 1'b1;
                end
                if (!weight_last && at_end) begin
                    err_long <= 1'b1;
                end
            end
        end
    end

    // Buffer contents survive reset on purpose
    always_ff @(posedge sclk) begin
        if (!s_rst && beat_acc) begin
            mem[wr_cnt] <= weight_data;
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en && (state == DONE);
            if (rd_en && (state == DONE)) begin
                rd_data <= addr_ok ? mem[rd_addr] : '0;
            end
        end
    end

`ifdef WEIGHT_CHKSUM_EN
    function automatic logic [7:0] byte_xor(input logic [63:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) begin
            x = x ^ w[i*8 +: 8];
        end
        return x;
    endfunction

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            chksum <= '0;
        end else if (start) begin
            chksum <= '0;
        end else if (beat_acc) begin
            chksum <= chksum ^ byte_xor(weight_data);
        end
    end
`endif

endmodule

// File: tb/tb_layer_weight_rx.sv
// Directed bench for layer_weight_rx: full, gapped, short, long and reset-interrupted loads plus reads.
// Define WEIGHT_CHKSUM_EN to also check the checksum output.
module tb_layer_weight_rx;

    localparam int DEPTH = 144;
    localparam int AW    = 8;

    logic          sclk;
    logic          s_rst;
    logic          load_start;
    logic [63:0]   weight_data;
    logic          weight_valid;
    logic          weight_last;
    logic          ready;
    logic          load_done;
    logic          err_short;
    logic          err_long;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic          rd_valid;
`ifdef WEIGHT_CHKSUM_EN
    logic [7:0]    chksum;
`endif

    int n_chk;
    int n_pass;

    logic [63:0] exp_mem [256];
    logic [7:0]  exp_sum;

    layer_weight_rx #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .sclk        (sclk),
        .s_rst       (s_rst),
        .load_start  (load_start),
        .weight_data (weight_data),
        .weight_valid(weight_valid),
        .weight_last (weight_last),
        .ready       (ready),
        .load_done   (load_done),
        .err_short   (err_short),
        .err_long    (err_long),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
`ifdef WEIGHT_CHKSUM_EN
        ,
        .chksum      (chksum)
`endif
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word(input int seed, input int k);
        logic [31:0] s;
        logic [31:0] kk;
        s  = 32'(seed);
        kk = 32'(k);
        return {s[15:0], kk[15:0], (kk * 32'h9E37_79B9) ^ s};
    endfunction

    function automatic logic [7:0] bx(input logic [63:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) begin
            x = x ^ w[i*8 +: 8];
        end
        return x;
    endfunction

    // Drives n beats (last flagged at index last_at), optional random gaps;
    // acc returns how many beats the handshake took.
    task automatic drive_beats(input int seed, input int n, input int last_at,
                               input int gap_pct, input int max_cyc, output int acc);
        int cyc;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < max_cyc) begin
            @(negedge sclk);
            cyc++;
            weight_valid = ($urandom_range(99) >= gap_pct);
            weight_data  = word(seed, acc);
            weight_last  = (acc == last_at);
            if (weight_valid && ready) begin
                exp_mem[acc] = weight_data;
                exp_sum      = exp_sum ^ bx(weight_data);
                acc++;
            end
        end
        @(negedge sclk);
        weight_valid = 1'b0;
        weight_last  = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge sclk);
        load_start = 1'b0;
        exp_sum    = '0;
    endtask

    // Reads 0..n-1 back-to-back and returns the number of wrong words
    task automatic read_back(input int n, output int bad);
        bad = 0;
        for (int a = 0; a <= n; a++) begin
            @(negedge sclk);
            if (a > 0) begin
                if (!rd_valid || rd_data !== exp_mem[a-1]) begin
                    bad++;
                end
            end
            rd_en   = (a < n);
            rd_addr = AW'(a);
        end
        rd_en = 1'b0;
    endtask

    int acc;
    int bad;

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        exp_sum      = '0;
        s_rst        = 1'b1;
        load_start   = 1'b0;
        weight_data  = '0;
        weight_valid = 1'b0;
        weight_last  = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;
        repeat (3) @(negedge sclk);
        s_rst = 1'b0;

        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_errs", 64'({err_short, err_long}), 64'd0);
        chk("rst_rdv", 64'(rd_valid), 64'd0);
        chk("rst_rdd", rd_data, 64'd0);

        // Upstream pushes while IDLE: must not be taken
        weight_valid = 1'b1;
        weight_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        rd_en        = 1'b1;
        rd_addr      = '0;
        @(negedge sclk);
        chk("idle_rdv", 64'(rd_valid), 64'd0);
        rd_en = 1'b0;
        @(negedge sclk);
        chk("idle_ready", 64'(ready), 64'd0);
        weight_valid = 1'b0;

        // Full load, valid always high
        pulse_start();
        chk("load_ready", 64'(ready), 64'd1);
        drive_beats(1, DEPTH, DEPTH - 1, 0, 400, acc);
        chk("full_acc", 64'(acc), 64'd144);
        chk("full_done", 64'(load_done), 64'd1);
        chk("full_ready", 64'(ready), 64'd0);
        chk("full_errs", 64'({err_short, err_long}), 64'd0);
        read_back(DEPTH, bad);
        chk("full_mem", 64'(bad), 64'd0);

        // Gapped load
        pulse_start();
        drive_beats(2, DEPTH, DEPTH - 1, 30, 1000, acc);
        chk("gap_acc", 64'(acc), 64'd144);
        chk("gap_done", 64'(load_done), 64'd1);
        read_back(DEPTH, bad);
        chk("gap_mem", 64'(bad), 64'd0);

        // Reads: 0, 143, out of range
        @(negedge sclk);
        rd_en   = 1'b1;
        rd_addr = 8'd0;
        @(negedge sclk);
        rd_addr = 8'd143;
        chk("rd0_v", 64'(rd_valid), 64'd1);
        chk("rd0_d", rd_data, exp_mem[0]);
        @(negedge sclk);
        rd_addr = 8'd200;
        chk("rd143_v", 64'(rd_valid), 64'd1);
        chk("rd143_d", rd_data, exp_mem[143]);
        @(negedge sclk);
        rd_en = 1'b0;
        chk("rd200_v", 64'(rd_valid), 64'd1);
        chk("rd200_d", rd_data, 64'd0);

        // Read issued together with load_start still completes
        rd_en      = 1'b1;
        rd_addr    = 8'd5;
        load_start = 1'b1;
        @(negedge sclk);
        load_start = 1'b0;
        rd_en      = 1'b0;
        exp_sum    = '0;
        chk("rdst_v", 64'(rd_valid), 64'd1);
        chk("rdst_d", rd_data, exp_mem[5]);
        chk("rdst_done", 64'(load_done), 64'd0);

        // Short load: last on beat 99 (continuing the load just started)
        drive_beats(3, 100, 99, 0, 300, acc);
        chk("short_acc", 64'(acc), 64'd100);
        chk("short_err", 64'({err_short, err_long}), 64'b10);
        chk("short_done", 64'(load_done), 64'd1);
        read_back(100, bad);
        chk("short_mem", 64'(bad), 64'd0);

        // Long load: no last; beat 144 must stall
        pulse_start();
        chk("long_clr", 64'({err_short, err_long, load_done}), 64'd0);
        drive_beats(4, DEPTH + 1, -1, 0, DEPTH + 10, acc);
        chk("long_acc", 64'(acc), 64'd144);
        chk("long_err", 64'({err_short, err_long}), 64'b01);
        chk("long_ready", 64'(ready), 64'd0);
        chk("long_done", 64'(load_done), 64'd1);

        // Reset mid-load, then a clean full load
        pulse_start();
        drive_beats(5, 50, -1, 0, 200, acc);
        s_rst = 1'b1;
        @(negedge sclk);
        s_rst = 1'b0;
        chk("mrst_st", 64'({ready, load_done, err_short, err_long, rd_valid}), 64'd0);
        chk("mrst_rdd", rd_data, 64'd0);
        pulse_start();
        drive_beats(6, DEPTH, DEPTH - 1, 10, 600, acc);
        chk("final_acc", 64'(acc), 64'd144);
        chk("final_st", 64'({load_done, err_short, err_long}), 64'b100);
`ifdef WEIGHT_CHKSUM_EN
        chk("final_sum", 64'(chksum), 64'(exp_sum));
`endif
        read_back(DEPTH, bad);
        chk("final_mem", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/layer_weight_rx.md
LAYER_WEIGHT_RX -- requirements
Module: layer_weight_rx

Interface
REQ-001 Parameter DEPTH, default 144, meaning number of 64-bit weight words per layer load.
REQ-002 Parameter AW, default 8, meaning address width, with 2^AW >= DEPTH.
REQ-003 Port sclk, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-004 Port s_rst, input, 1, meaning synchronous active-high reset.
REQ-005 Port load_start, input, 1, meaning a one-cycle pulse that arms a new weight load.
REQ-006 Port weight_data, input, 64, meaning the stream payload (8 bytes, byte0 in bits [7:0]).
REQ-007 Port weight_valid, input, 1, meaning the upstream beat is valid.
REQ-008 Port weight_last, input, 1, meaning the final beat of the load.
REQ-009 Port ready, output, 1, meaning the block accepts a beat this cycle.
REQ-010 Port load_done, output, 1, meaning the buffer holds a complete load; level signal.
REQ-011 Port err_short, output, 1, meaning weight_last arrived before beat DEPTH; sticky until next load_start.
REQ-012 Port err_long, output, 1, meaning DEPTH beats were taken without weight_last; sticky until next load_start.
REQ-013 Port rd_en, input, 1, meaning a read request from the conv engine.
REQ-014 Port rd_addr, input, AW, meaning the word address to read.
REQ-015 Port rd_data, output, 64, meaning the read word.
REQ-016 Port rd_valid, output, 1, meaning rd_data is valid.

Function
REQ-017 FSM states: IDLE, LOAD, DONE.
REQ-018 IDLE goes to LOAD on load_start; LOAD goes to DONE on an accepted beat with weight_last=1 or with wr_cnt==DEPTH-1; DONE goes to LOAD on load_start.
REQ-019 ready=1 only in LOAD; it is a registered output asserted the cycle after entering LOAD and deasserted the cycle after the terminating beat.
REQ-020 Accepted beat = weight_valid & ready; each accepted beat writes weight_data to mem[wr_cnt], then wr_cnt increments.
REQ-021 wr_cnt clears to 0 on entering LOAD; it is never wrapped, because LOAD always exits at DEPTH beats.
REQ-022 On a terminating beat with weight_last=1 and wr_cnt<DEPTH-1, the block sets err_short and goes to DONE; the data written so far is kept.
REQ-023 On beat DEPTH-1 accepted with weight_last=0, the block sets err_long and goes to DONE; further upstream beats stall because ready=0.
REQ-024 On beat DEPTH-1 with weight_last=1, the load is normal: no error is raised.
REQ-025 load_done=1 in DONE only; it clears the cycle after load_start.
REQ-026 load_start in LOAD is ignored, and the current load continues.
REQ-027 Reads are serviced only in DONE: rd_en=1 gives rd_data=mem[rd_addr] and rd_valid=1 exactly one cycle later.
REQ-028 rd_en outside DONE gives rd_valid=0 the next cycle; rd_data is then don't-care.
REQ-029 rd_en with rd_addr>=DEPTH gives rd_valid=1 and rd_data=0.
REQ-030 In the cycle DONE goes to LOAD on load_start, a read issued that cycle still completes (rd_valid=1 next cycle).

Reset
REQ-031 s_rst=1 at a clock edge forces: state IDLE, ready=0, load_done=0, err_short=0, err_long=0, rd_valid=0, rd_data=0, wr_cnt=0.
REQ-032 Reset mid-LOAD abandons the load; memory contents are not cleared.

Configuration
REQ-033 Macro WEIGHT_CHKSUM_EN, when defined, adds output chksum[7:0]: the XOR of all bytes of all accepted beats, cleared on load_start and reset, and final when load_done rises.
REQ-034 Without WEIGHT_CHKSUM_EN, the chksum port and its logic are absent; all other behaviour is identical.

Verification
REQ-035 Reset, load_start, 144 beats with last on beat 143, valid always high -> load_done=1, no errors, ready low after beat 143, and 144 accepted beats.
REQ-036 Random valid gaps, plus ready-driven backpressure before load_start -> no beats accepted in IDLE, and the memory matches the sent data in order.
REQ-037 Last on beat 99 -> err_short=1, load_done=1, and mem[0..99] correct.
REQ-038 144 beats with last=0 -> err_long=1, ready=0 after beat 143, and beat 144 is held un-accepted.
REQ-039 In DONE, rd_en with addr 0, 143 and 200 on consecutive cycles -> rd_valid on the next three cycles, with data word0, word143 and 0; rd_en in IDLE -> rd_valid=0.
REQ-040 Reset asserted at beat 50, then a full new load -> clean DONE; with WEIGHT_CHKSUM_EN defined, chksum equals the bench XOR of all 1152 bytes.
